// File: rtl/mbus_ice_driver_rx_if.sv
// Bus bundle between the MBus node rx port / ICE character consumer and the rx driver.
// master: the environment (node and consumer); slave: the rx driver.
interface mbus_ice_driver_rx_if;
  logic [31:0] rx_mbus_rxaddr;
  logic [31:0] rx_mbus_rxdata;
  logic        rx_mbus_rxreq;
  logic        rx_mbus_rxpend;
  logic        rx_mbus_rxbroadcast;
  logic        rx_mbus_rxfail;
  logic        rx_mbus_rxack;
  logic        rx_frame_valid;
  logic [7:0]  rx_char;
  logic        rx_char_valid;
  logic        rx_char_ready;

  modport master (
    output rx_mbus_rxaddr, rx_mbus_rxdata, rx_mbus_rxreq, rx_mbus_rxpend,
           rx_mbus_rxbroadcast, rx_mbus_rxfail, rx_char_ready,
    input  rx_mbus_rxack, rx_frame_valid, rx_char, rx_char_valid
  );

  modport slave (
    input  rx_mbus_rxaddr, rx_mbus_rxdata, rx_mbus_rxreq, rx_mbus_rxpend,
           rx_mbus_rxbroadcast, rx_mbus_rxfail, rx_char_ready,
    output rx_mbus_rxack, rx_frame_valid, rx_char, rx_char_valid
  );
endinterface

// File: rtl/mbus_ice_driver_rx.sv
// Receive-side ICE MBus driver: accepts MBus rx words over the 4-phase handshake and
// serializes address, data words and two status bytes into the ICE character stream.
module mbus_ice_driver_rx #(
  parameter int unsigned WAIT_TIMEOUT = 0
) (
  input logic                 clk,
  input logic                 reset,
  mbus_ice_driver_rx_if.slave bus
);

  localparam int unsigned TW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = (WAIT_TIMEOUT == 0) ? '0 : TW'(WAIT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_RX_IDLE,
    ST_RX_ACK,
    ST_RX_ADDR,
    ST_RX_DATA,
    ST_RX_WAIT_NEXT,
    ST_RX_FAIL_ACK,
    ST_RX_STAT0,
    ST_RX_STAT1
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic          pend_q, pend_d;
  logic          bcast_q, bcast_d;
  logic          fail_q, fail_d;
  logic          first_q, first_d;
  logic [7:0]    count_q, count_d;
  logic [1:0]    idx_q, idx_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          ack_q, ack_d;
  logic          fv_q, fv_d;
  logic [7:0]    char_q, char_d;
  logic          cv_q, cv_d;
  logic          xfer;

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    byte_of = w[31:24];
      2'd1:    byte_of = w[23:16];
      2'd2:    byte_of = w[15:8];
      default: byte_of = w[7:0];
    endcase
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    sat_inc = (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  function automatic logic [7:0] status_byte(input logic bc, input logic fl);
    status_byte = {6'b0, bc, fl};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RX_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      pend_q  <= 1'b0;
      bcast_q <= 1'b0;
      fail_q  <= 1'b0;
      first_q <= 1'b0;
      count_q <= '0;
      idx_q   <= '0;
      tcnt_q  <= '0;
      ack_q   <= 1'b0;
      fv_q    <= 1'b0;
      char_q  <= '0;
      cv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      pend_q  <= pend_d;
      bcast_q <= bcast_d;
      fail_q  <= fail_d;
      first_q <= first_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      tcnt_q  <= tcnt_d;
      ack_q   <= ack_d;
      fv_q    <= fv_d;
      char_q  <= char_d;
      cv_q    <= cv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    pend_d  = pend_q;
    bcast_d = bcast_q;
    fail_d  = fail_q;
    first_d = first_q;
    count_d = count_q;
    idx_d   = idx_q;
    tcnt_d  = tcnt_q;
    ack_d   = ack_q;
    fv_d    = fv_q;
    char_d  = char_q;
    cv_d    = cv_q;
    xfer    = cv_q && bus.rx_char_ready;

    case (state_q)
      ST_RX_IDLE: begin
        if (bus.rx_mbus_rxreq) begin
          addr_d  = bus.rx_mbus_rxaddr;
          data_d  = bus.rx_mbus_rxdata;
          pend_d  = bus.rx_mbus_rxpend;
          bcast_d = bus.rx_mbus_rxbroadcast;
          fail_d  = 1'b0;
          first_d = 1'b1;
          count_d = 8'd1;
          ack_d   = 1'b1;
          fv_d    = 1'b1;
          state_d = ST_RX_ACK;
        end
      end

      ST_RX_ACK: begin
        // The first character goes out together with the ack release, so no bubble.
        if (!bus.rx_mbus_rxreq) begin
          ack_d = 1'b0;
          idx_d = 2'd0;
          cv_d  = 1'b1;
          if (first_q) begin
            state_d = ST_RX_ADDR;
            char_d  = byte_of(addr_q, 2'd0);
          end else begin
            state_d = ST_RX_DATA;
            char_d  = byte_of(data_q, 2'd0);
          end
        end
      end

      ST_RX_ADDR: begin
        if (xfer) begin
          if (idx_q == 2'd3) begin
            idx_d   = 2'd0;
            state_d = ST_RX_DATA;
            char_d  = byte_of(data_q, 2'd0);
          end else begin
            idx_d  = idx_q + 2'd1;
            char_d = byte_of(addr_q, idx_q + 2'd1);
          end
        end
      end

      ST_RX_DATA: begin
        if (xfer) begin
          if (idx_q == 2'd3) begin
            idx_d = 2'd0;
            if (pend_q) begin
              cv_d    = 1'b0;
              tcnt_d  = '0;
              state_d = ST_RX_WAIT_NEXT;
            end else begin
              char_d  = status_byte(bcast_q, fail_q);
              state_d = ST_RX_STAT0;
            end
          end else begin
            idx_d  = idx_q + 2'd1;
            char_d = byte_of(data_q, idx_q + 2'd1);
          end
        end
      end

      ST_RX_WAIT_NEXT: begin
        // A request beats a simultaneous fail; the fail is seen again on a later visit.
        if (bus.rx_mbus_rxreq) begin
          data_d  = bus.rx_mbus_rxdata;
          pend_d  = bus.rx_mbus_rxpend;
          count_d = sat_inc(count_q);
          first_d = 1'b0;
          ack_d   = 1'b1;
          state_d = ST_RX_ACK;
        end else if (bus.rx_mbus_rxfail) begin
          fail_d  = 1'b1;
          ack_d   = 1'b1;
          state_d = ST_RX_FAIL_ACK;
        end else if (WAIT_TIMEOUT != 0) begin
          if (tcnt_q == T_LAST) begin
            fail_d  = 1'b1;
            char_d  = status_byte(bcast_q, 1'b1);
            cv_d    = 1'b1;
            state_d = ST_RX_STAT0;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end

      ST_RX_FAIL_ACK: begin
        if (!bus.rx_mbus_rxfail) begin
          ack_d   = 1'b0;
          char_d  = status_byte(bcast_q, fail_q);
          cv_d    = 1'b1;
          state_d = ST_RX_STAT0;
        end
      end

      ST_RX_STAT0: begin
        if (xfer) begin
          char_d  = count_q;
          state_d = ST_RX_STAT1;
        end
      end

      ST_RX_STAT1: begin
        if (xfer) begin
          char_d  = '0;
          cv_d    = 1'b0;
          fv_d    = 1'b0;
          state_d = ST_RX_IDLE;
        end
      end

      default: state_d = ST_RX_IDLE;
    endcase
  end

  assign bus.rx_mbus_rxack  = ack_q;
  assign bus.rx_frame_valid = fv_q;
  assign bus.rx_char        = char_q;
  assign bus.rx_char_valid  = cv_q;

endmodule

// File: tb/tb_mbus_ice_driver_rx.sv
// Bench for mbus_ice_driver_rx: every frame is modelled as a queue of expected bytes that is
// matched against the character stream each falling edge, with handshake and framing rules.
`timescale 1ns/1ps
module tb_mbus_ice_driver_rx;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  logic [8:0]  exp_q[$];
  logic [7:0]  log_q[$];
  logic [31:0] dq[$];
  int pops = 0;
  int ready_mode = 0;

  always #5 clk = ~clk;

  mbus_ice_driver_rx_if bus ();
  mbus_ice_driver_rx #(.WAIT_TIMEOUT(TMO)) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle rule checker and byte scoreboard.
  logic p_cv = 1'b0, p_rdy = 1'b0, p_ack = 1'b0, p_fv = 1'b0;
  logic p_req = 1'b0, p_fail = 1'b0, drop_due = 1'b0;
  logic [7:0] p_char = 8'h00;

  always @(negedge clk) begin
    if (reset) begin
      p_cv <= 1'b0; p_rdy <= 1'b0; p_ack <= 1'b0; p_fv <= 1'b0;
      p_req <= 1'b0; p_fail <= 1'b0; drop_due <= 1'b0; p_char <= 8'h00;
    end else begin
      drop_due <= 1'b0;
      if (drop_due) begin
        chk("frame_end_fv", bus.rx_frame_valid, 1'b0);
        chk("frame_end_cv", bus.rx_char_valid, 1'b0);
      end else if (p_fv) begin
        chk("frame_hold", bus.rx_frame_valid, 1'b1);
      end
      if (bus.rx_char_valid) chk("char_in_frame", bus.rx_frame_valid, 1'b1);
      if (p_cv && !p_rdy) begin
        chk("stall_valid", bus.rx_char_valid, 1'b1);
        chk("stall_char", bus.rx_char, p_char);
      end
      if (bus.rx_mbus_rxack && !p_ack) begin
        chk("ack_cause", p_req | p_fail, 1'b1);
        chk("ack_while_char", p_cv | bus.rx_char_valid, 1'b0);
      end
      if (bus.rx_char_valid && bus.rx_char_ready) begin
        chk("byte_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          chk("byte", bus.rx_char, exp_q[0][7:0]);
          drop_due <= exp_q[0][8];
          void'(exp_q.pop_front());
          log_q.push_back(bus.rx_char);
          pops <= pops + 1;
        end
      end
      p_cv   <= bus.rx_char_valid;
      p_rdy  <= bus.rx_char_ready;
      p_ack  <= bus.rx_mbus_rxack;
      p_fv   <= bus.rx_frame_valid;
      p_req  <= bus.rx_mbus_rxreq;
      p_fail <= bus.rx_mbus_rxfail;
      p_char <= bus.rx_char;
    end
  end

  // Consumer readiness: always, random, or the repeating 1,0,0,1 pattern.
  initial begin
    int ph = 0;
    logic [3:0] pat = 4'b1001;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.rx_char_ready = 1'b1;
        1:       bus.rx_char_ready = 1'($urandom_range(0, 1));
        default: begin bus.rx_char_ready = pat[ph]; ph = (ph + 1) % 4; end
      endcase
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic push_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) exp_q.push_back({1'b0, w[8*b +: 8]});
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin step(); n++; end
    if (exp_q.size() != 0) chk("drain_bound", exp_q.size(), 0);
  endtask

  task automatic handshake(input bit prompt);
    int n = 0;
    while (bus.rx_mbus_rxack !== 1'b1 && n < 300) begin step(); n++; end
    chk("ack_seen", bus.rx_mbus_rxack, 1'b1);
    if (prompt) chk("ack_latency", n, 1);
    repeat ($urandom_range(0, 2)) begin
      step();
      chk("ack_hold", bus.rx_mbus_rxack, 1'b1);
    end
    bus.rx_mbus_rxreq = 1'b0;
    step();
    chk("ack_release", bus.rx_mbus_rxack, 1'b0);
  endtask

  // end_mode: 0 = last word has pend=0, 1 = node fail after last word, 2 = wait timeout.
  task automatic send_msg(input logic [31:0] addr, input int n, input logic bc,
                          input int end_mode, input bit early);
    logic [7:0] cnt;
    logic [7:0] stat;
    logic [31:0] d;
    bit prompt;
    int k;
    cnt  = (n > 255) ? 8'hFF : 8'(n);
    stat = {6'b0, bc, end_mode != 0};
    log_q.delete();
    for (int i = 0; i < n; i++) begin
      if (i == 0 || !early || $urandom_range(0, 1) == 0) begin
        wait_drain();
        repeat ($urandom_range(0, 4)) step();
        prompt = 1'b1;
      end else begin
        prompt = 1'b0;
      end
      d = (dq.size() > 0) ? dq.pop_front() : $urandom();
      bus.rx_mbus_rxaddr      = (i == 0) ? addr : $urandom();
      bus.rx_mbus_rxdata      = d;
      bus.rx_mbus_rxpend      = (i < n - 1) || (end_mode != 0);
      bus.rx_mbus_rxbroadcast = (i == 0) ? bc : 1'($urandom());
      if (i == 0) push_word(addr);
      push_word(d);
      if (i == n - 1 && end_mode == 0) begin
        exp_q.push_back({1'b0, stat});
        exp_q.push_back({1'b1, cnt});
      end
      bus.rx_mbus_rxreq = 1'b1;
      handshake(prompt);
      if (i == 0) chk("frame_start", bus.rx_frame_valid, 1'b1);
    end
    if (end_mode == 1) begin
      wait_drain();
      repeat ($urandom_range(0, 4)) step();
      exp_q.push_back({1'b0, stat});
      exp_q.push_back({1'b1, cnt});
      bus.rx_mbus_rxfail = 1'b1;
      step();
      chk("fail_ack", bus.rx_mbus_rxack, 1'b1);
      step();
      chk("fail_ack_hold", bus.rx_mbus_rxack, 1'b1);
      step();
      bus.rx_mbus_rxfail = 1'b0;
      step();
      chk("fail_ack_release", bus.rx_mbus_rxack, 1'b0);
    end else if (end_mode == 2) begin
      wait_drain();
      exp_q.push_back({1'b0, stat});
      exp_q.push_back({1'b1, cnt});
      k = 0;
      while (!bus.rx_char_valid && k < 100) begin step(); k++; end
      chk("timeout_cycles", k, TMO);
    end
    wait_drain();
    repeat (2) step();
  endtask

  initial begin
    logic [7:0] lit1 [10] = '{8'h00, 8'h00, 8'h00, 8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h01};
    int k;
    reset = 1'b1;
    bus.rx_mbus_rxaddr = '0;
    bus.rx_mbus_rxdata = '0;
    bus.rx_mbus_rxreq = 1'b0;
    bus.rx_mbus_rxpend = 1'b0;
    bus.rx_mbus_rxbroadcast = 1'b0;
    bus.rx_mbus_rxfail = 1'b0;
    bus.rx_char_ready = 1'b0;
    repeat (3) step();
    chk("rst_ack", bus.rx_mbus_rxack, 1'b0);
    chk("rst_fv", bus.rx_frame_valid, 1'b0);
    chk("rst_cv", bus.rx_char_valid, 1'b0);
    chk("rst_char", bus.rx_char, 8'h00);
    reset = 1'b0;
    step();

    // Single word, consumer always ready.
    ready_mode = 0;
    dq.push_back(32'hDEAD_BEEF);
    send_msg(32'h0000_00A5, 1, 1'b0, 0, 1'b0);
    chk("single_len", log_q.size(), 10);
    for (int i = 0; i < 10; i++) chk("single_lit", log_q[i], lit1[i]);

    // Three-word broadcast message.
    dq.push_back(32'h1111_1111);
    dq.push_back(32'h2222_2222);
    dq.push_back(32'h3333_3333);
    send_msg(32'h0000_00F0, 3, 1'b1, 0, 1'b0);
    chk("three_len", log_q.size(), 18);
    chk("three_w1", log_q[4], 8'h11);
    chk("three_w2", log_q[11], 8'h22);
    chk("three_w3", log_q[15], 8'h33);
    chk("three_st0", log_q[16], 8'h02);
    chk("three_st1", log_q[17], 8'h03);

    // Backpressure pattern with next requests raised mid-word.
    ready_mode = 2;
    send_msg($urandom(), 3, 1'b0, 0, 1'b1);
    chk("bp_len", log_q.size(), 18);
    chk("bp_cnt", log_q[17], 8'h03);

    // Node-reported failure after word 1.
    ready_mode = 0;
    send_msg(32'h0000_0010, 1, 1'b0, 1, 1'b0);
    chk("fail_len", log_q.size(), 10);
    chk("fail_st0", log_q[8], 8'h01);
    chk("fail_st1", log_q[9], 8'h01);

    // Timeout waiting for word 2.
    send_msg(32'h0000_0020, 1, 1'b0, 2, 1'b0);
    chk("tmo_len", log_q.size(), 10);
    chk("tmo_st0", log_q[8], 8'h01);
    chk("tmo_st1", log_q[9], 8'h01);

    // Reset after 5 bytes of a frame, then a clean single-word frame.
    ready_mode = 1;
    log_q.delete();
    pops = 0;
    bus.rx_mbus_rxaddr = 32'h1234_5678;
    bus.rx_mbus_rxdata = 32'hCAFE_F00D;
    bus.rx_mbus_rxpend = 1'b0;
    bus.rx_mbus_rxbroadcast = 1'b0;
    push_word(32'h1234_5678);
    push_word(32'hCAFE_F00D);
    exp_q.push_back(9'h000);
    exp_q.push_back(9'h101);
    bus.rx_mbus_rxreq = 1'b1;
    handshake(1'b1);
    k = 0;
    while (pops < 5 && k < 500) begin step(); k++; end
    chk("rstmid_bytes", pops, 5);
    reset = 1'b1;
    step();
    chk("rstmid_ack", bus.rx_mbus_rxack, 1'b0);
    chk("rstmid_fv", bus.rx_frame_valid, 1'b0);
    chk("rstmid_cv", bus.rx_char_valid, 1'b0);
    chk("rstmid_char", bus.rx_char, 8'h00);
    exp_q.delete();
    reset = 1'b0;
    step();
    ready_mode = 0;
    dq.push_back(32'h0102_0304);
    send_msg(32'h0000_0042, 1, 1'b0, 0, 1'b0);
    chk("post_rst_len", log_q.size(), 10);
    chk("post_rst_addr", log_q[3], 8'h42);
    chk("post_rst_data", log_q[7], 8'h04);
    chk("post_rst_cnt", log_q[9], 8'h01);

    // Randomized messages.
    for (int m = 0; m < 30; m++) begin
      int r;
      r = int'($urandom_range(0, 5));
      ready_mode = int'($urandom_range(0, 2));
      send_msg($urandom(), int'($urandom_range(1, 5)), 1'($urandom()),
               (r < 4) ? 0 : r - 3, 1'($urandom()));
    end

    // Word count saturation.
    ready_mode = 0;
    send_msg(32'h0000_0077, 257, 1'b0, 0, 1'b0);
    chk("sat_len", log_q.size(), 4 + 257 * 4 + 2);
    chk("sat_st0", log_q[log_q.size() - 2], 8'h00);
    chk("sat_cnt", log_q[log_q.size() - 1], 8'hFF);

    repeat (3) step();
    chk("end_idle_fv", bus.rx_frame_valid, 1'b0);
    chk("end_queue", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mbus_ice_driver_rx.md
Name: mbus_ice_driver_rx

Overview:
- Receive-side counterpart of the ICE MBus transmit driver.
- Accepts received MBus messages as a 32-bit address plus one or more 32-bit data words over the MBus rx request/ack handshake.
- Serializes each message MSB-first into the 8-bit character stream of the ICE bus interface, framed and terminated by two status bytes (flags, word count).
- Sits between the MBus node rx port and the ICE bus-interface response/event path.

Parameters:
- WAIT_TIMEOUT, 0: cycles to wait in ST_RX_WAIT_NEXT for the next word of a pending message. 0 disables the timeout. Expiry terminates the message with the fail flag set.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- rx_mbus_rxaddr  input  32  received MBus address; valid while rx_mbus_rxreq is high
- rx_mbus_rxdata  input  32  received data word; valid while rx_mbus_rxreq is high
- rx_mbus_rxreq  input  1  word-available request from MBus node (4-phase)
- rx_mbus_rxpend  input  1  more words follow this one
- rx_mbus_rxbroadcast  input  1  message is broadcast; sampled with the first word
- rx_mbus_rxfail  input  1  node reports the in-progress message failed
- rx_mbus_rxack  output  1  acknowledge to node (4-phase)
- rx_frame_valid  output  1  high for the whole outgoing frame
- rx_char  output  8  outgoing character
- rx_char_valid  output  1  rx_char is valid
- rx_char_ready  input  1  consumer accepts rx_char this cycle

Behaviour:
- Reset values: all outputs 0; state ST_RX_IDLE; latched addr/data, word count, flags and timeout counter cleared. Reset mid-operation abandons the frame immediately: rx_frame_valid and rx_mbus_rxack drop in the next cycle. No status bytes are emitted.
- All outputs are registered.
- Byte transfer: occurs on any cycle where rx_char_valid and rx_char_ready are both high. rx_char must be stable while rx_char_valid is high and rx_char_ready is low.
- rx_char_valid is never withdrawn without a transfer.
- Bytes within a word are sent MSB first.
- Word count is 8 bits, counts data words accepted, and saturates at 255.
- ST_RX_IDLE: if rx_mbus_rxreq is sampled high at edge N, then at N+1: addr/data/pend/broadcast latched, rxack=1, rx_frame_valid=1, word count=1 → ST_RX_ACK.
- ST_RX_ACK: hold rxack until rx_mbus_rxreq is sampled low, then clear rxack next cycle. Go to ST_RX_ADDR if this is the first word, else ST_RX_DATA.
- ST_RX_ADDR: emit 4 address bytes (2-bit byte index) → ST_RX_DATA.
- ST_RX_DATA: emit 4 data bytes. After the last transfer: if latched pend=1 → ST_RX_WAIT_NEXT, else → ST_RX_STAT0.
- ST_RX_WAIT_NEXT: clear timeout counter on entry.
  - rx_mbus_rxreq=1: latch data and pend, increment count, rxack=1 → ST_RX_ACK.
  - Else rx_mbus_rxfail=1: set fail flag, rxack=1 → ST_RX_FAIL_ACK.
  - Else, if WAIT_TIMEOUT≠0 and the counter reaches WAIT_TIMEOUT: set fail flag → ST_RX_STAT0 (no ack).
  - If rxreq and rxfail are high together, rxreq wins; rxfail is re-evaluated on the next visit.
- ST_RX_FAIL_ACK: hold rxack until rx_mbus_rxfail is low, then clear → ST_RX_STAT0.
- ST_RX_STAT0: emit {6'b0, broadcast, fail} → ST_RX_STAT1.
- ST_RX_STAT1: emit word count. After the transfer, rx_frame_valid drops next cycle → ST_RX_IDLE. The earliest a new rxreq is accepted is the cycle after that.
- Backpressure: a new rxreq arriving during serialization is not acknowledged until the block returns to ST_RX_IDLE or ST_RX_WAIT_NEXT. The MBus node is stalled; no buffering beyond one word.
- rx_mbus_rxfail in any state other than ST_RX_WAIT_NEXT is ignored.

Test Plan:
- Single word: addr 32'h0000_00A5, data 32'hDEAD_BEEF, pend=0, broadcast=0, ready always 1 → chars 00 00 00 A5 DE AD BE EF 00 01. rxack high exactly from one cycle after rxreq rises until one cycle after rxreq falls. rx_frame_valid spans all 10 bytes.
- Three-word pend message, broadcast=1, data 11111111/22222222/33333333 → addr bytes, then 12 data bytes in order, then status 02 03. Each rxreq is acked only in ST_RX_IDLE/ST_RX_WAIT_NEXT.
- Backpressure: ready toggles 1,0,0,1 during data bytes → no byte is lost or duplicated. rx_char is stable while stalled. A second rxreq raised mid-word is not acked until serialization of the current word ends.
- Failure: pend=1 on word 1, then rx_mbus_rxfail pulsed for 3 cycles → rxack follows the fail handshake, status bytes 01 01.
- Timeout: WAIT_TIMEOUT=16, pend=1, no further rxreq → status 01 01 emitted after 16 cycles. rxack is never asserted after word 1.
- Reset mid-frame after 5 bytes → next cycle all outputs 0. A subsequent single-word message is framed correctly with count 01.
